// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: hazard sources in, latch controls
// and performance counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             dREN_mem;
    logic             dWEN_mem;
    logic             dREN_ex;
    logic [REG_W-1:0] rd_ex;
    logic [REG_W-1:0] rs_dec;
    logic [REG_W-1:0] rt_dec;
    logic             redirect_ex;
    logic             jump_dec;
    logic             halt_mw;
    logic             pc_en;
    logic             en_fd;
    logic             flush_fd;
    logic             en_de;
    logic             flush_de;
    logic             en_em;
    logic             flush_em;
    logic             en_mw;
    logic             flush_mw;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, dREN_mem, dWEN_mem, dREN_ex,
        output rd_ex, rs_dec, rt_dec,
        output redirect_ex, jump_dec, halt_mw,
        input  pc_en, en_fd, flush_fd, en_de, flush_de,
        input  en_em, flush_em, en_mw, flush_mw,
        input  halt, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, dREN_mem, dWEN_mem, dREN_ex,
        input  rd_ex, rs_dec, rt_dec,
        input  redirect_ex, jump_dec, halt_mw,
        output pc_en, en_fd, flush_fd, en_de, flush_de,
        output en_em, flush_em, en_mw, flush_mw,
        output halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch enable/flush generation for cache waits,
// load-use, redirects and halt, plus stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input logic CLK,
    input logic nRST,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, HALTED} state_e;

    state_e           state_q, state_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic mem_busy, lu;
    logic pc_en, en_fd, flush_fd, en_de, flush_de;
    logic en_em, en_mw;

    assign mem_busy = (hz.dREN_mem | hz.dWEN_mem) & ~hz.dhit;
    assign lu = hz.dREN_ex & (hz.rd_ex != '0) &
                ((hz.rd_ex == hz.rs_dec) | (hz.rd_ex == hz.rt_dec));

    always_comb begin
        pc_en    = 1'b0;
        en_fd    = 1'b0;
        flush_fd = 1'b0;
        en_de    = 1'b0;
        flush_de = 1'b0;
        en_em    = 1'b0;
        en_mw    = 1'b0;
        pend_d   = pend_q;
        state_d  = state_q;
        if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (mem_busy) begin
            state_d = RUN;
        end else if (hz.redirect_ex) begin
            pc_en    = 1'b1;
            flush_fd = 1'b1;
            flush_de = 1'b1;
            en_em    = 1'b1;
            en_mw    = 1'b1;
            // the in-flight fetch is wrong-path if it has not landed yet
            pend_d   = ~hz.ihit;
        end else if (!hz.ihit) begin
            flush_de = 1'b1;
            en_em    = 1'b1;
            en_mw    = 1'b1;
        end else if (pend_q) begin
            pc_en    = 1'b1;
            flush_fd = 1'b1;
            en_de    = 1'b1;
            en_em    = 1'b1;
            en_mw    = 1'b1;
            pend_d   = 1'b0;
        end else if (lu) begin
            flush_de = 1'b1;
            en_em    = 1'b1;
            en_mw    = 1'b1;
        end else if (hz.jump_dec) begin
            pc_en    = 1'b1;
            flush_fd = 1'b1;
            en_de    = 1'b1;
            en_em    = 1'b1;
            en_mw    = 1'b1;
        end else begin
            pc_en    = 1'b1;
            en_fd    = 1'b1;
            en_de    = 1'b1;
            en_em    = 1'b1;
            en_mw    = 1'b1;
        end
        if (state_q == RUN && hz.halt_mw && !mem_busy) begin
            state_d = HALTED;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (state_q == RUN && !pc_en && !(&stall_q)) begin
            stall_d = stall_q + 1'b1;
        end
        if (state_q == RUN && (flush_fd | flush_de) && !(&flush_q)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign hz.pc_en     = pc_en;
    assign hz.en_fd     = en_fd;
    assign hz.flush_fd  = flush_fd;
    assign hz.en_de     = en_de;
    assign hz.flush_de  = flush_de;
    assign hz.en_em     = en_em;
    assign hz.flush_em  = 1'b0;
    assign hz.en_mw     = en_mw;
    assign hz.flush_mw  = 1'b0;
    assign hz.halt      = (state_q == HALTED);
    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;

    // enable wins in the latch, so both together would hide a flush
    a_excl: assert property (@(posedge CLK) disable iff (!nRST)
        !(en_fd && flush_fd) && !(en_de && flush_de));
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Control-side counterpart of the pipeline latches. Generates the per-latch enable/flush pairs for the four pipeline registers (fetch/decode, decode/execute, execute/memory, memory/writeback) and the PC enable.
- Resolves four hazard sources: cache waits, load-use hazards, control redirects and halt.
- Tracks redirects that occur while an instruction fetch is outstanding, so the stale instruction is squashed when it returns.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 32, performance-counter width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access in the memory stage completes this cycle.
- dREN_mem  in  1  memory-stage instruction is a load.
- dWEN_mem  in  1  memory-stage instruction is a store.
- dREN_ex  in  1  execute-stage instruction is a load.
- rd_ex  in  REG_W  execute-stage destination register.
- rs_dec  in  REG_W  decode-stage source register 1.
- rt_dec  in  REG_W  decode-stage source register 2.
- redirect_ex  in  1  branch taken or jr resolved in execute.
- jump_dec  in  1  j/jal in decode.
- halt_mw  in  1  halt instruction in writeback.
- pc_en  out  1  PC register update.
- en_fd, flush_fd  out  1 each  fetch/decode latch control.
- en_de, flush_de  out  1 each  decode/execute latch control.
- en_em, flush_em  out  1 each  execute/memory latch control.
- en_mw, flush_mw  out  1 each  memory/writeback latch control.
- halt  out  1  processor halted (registered).
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted.
- flush_cnt  out  CNT_W  cycles with any flush asserted.

Behaviour:
- Latch contract: in each latch, enable has priority over flush. This block never asserts en_X and flush_X together (assertion-checked). flush_em and flush_mw are tied 0.
- State: RUN or HALTED. Plus a pend flag (redirect issued while a fetch is outstanding).
- Reset: state=RUN, pend=0, halt=0, both counters 0. Combinational outputs then follow the RUN rules below.
- Derived terms:
  - mem_busy = (dREN_mem | dWEN_mem) & !dhit.
  - lu = dREN_ex & (rd_ex != 0) & (rd_ex == rs_dec | rd_ex == rt_dec).
- Output rules, first match wins; any output not named is 0:
  1. HALTED: all outputs 0; halt=1.
  2. mem_busy: all en and flush 0 (full freeze). pend and state unchanged.
  3. redirect_ex: pc_en=1, flush_fd=1, flush_de=1, en_em=1, en_mw=1. Applies regardless of ihit; if !ihit, set pend. Younger load-use and jump_dec are ignored.
  4. !ihit: en_em=1, en_mw=1, flush_de=1 (bubble into execute). fd holds.
  5. ihit & pend: the returning instruction is wrong-path. flush_fd=1, en_de=1, en_em=1, en_mw=1, pc_en=1. Clear pend. This rule takes precedence over lu and jump_dec.
  6. ihit & lu: en_em=1, en_mw=1, flush_de=1; pc_en=0, fd holds.
  7. ihit & jump_dec: pc_en=1, flush_fd=1, en_de=1, en_em=1, en_mw=1.
  8. Otherwise: pc_en and all en = 1.
- Halt: halt_mw & !mem_busy & state==RUN moves to HALTED next cycle and sets halt. Only reset leaves HALTED.
- Counters:
  - stall_cnt increments when state==RUN & pc_en==0.
  - flush_cnt increments when (flush_fd | flush_de) == 1.
  - Both saturate at all-ones and are frozen in HALTED.
- Asynchronous reset mid-operation clears pend and the counters immediately. No partial stall survives reset.
- Latency: all hazard outputs are combinational from current inputs and state. State, pend, halt and counters update on the rising edge of CLK.

Test Plan:
- Reset, then ihit=1, no hazards for 10 cycles -> pc_en and all en =1, flushes 0, stall_cnt=0, flush_cnt=0.
- dREN_mem=1, dhit=0 for 3 cycles, then dhit=1 -> all controls 0 for 3 cycles, normal on the 4th; stall_cnt=3.
- dREN_ex=1, rd_ex=8, rs_dec=8, ihit=1 -> one cycle with pc_en=0, en_fd=0, flush_de=1; rd_ex=0 with rs_dec=0 -> no stall.
- redirect_ex=1 with ihit=0, then ihit=1 two cycles later -> redirect cycle: pc_en=1, flush_fd=1, flush_de=1. On the ihit cycle: flush_fd=1, en_fd=0. pend cleared; the next ihit gives en_fd=1.
- jump_dec=1 and lu=1 with ihit=1 -> lu wins (pc_en=0); redirect_ex with lu -> redirect wins. Assertion: en_X & flush_X never both 1.
- halt_mw=1 -> next cycle halt=1, all controls 0. Counters hold for 20 cycles; only nRST low clears halt.
- Preload stall_cnt to saturation via a long stall with CNT_W overridden to 4 -> sticks at 15.
